mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter RAM_LAT, default 1, meaning: read latency in cycles from ram_ce=1 to ram_rdata valid; legal range 1..4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 m0_req  input  1  CPU MEM-stage request; held high with stable m0_we/addr/sel/wdata until m0_ack.
REQ-005 m0_we, m0_addr, m0_sel, m0_wdata  input  1/32/4/32  CPU write enable, byte address, byte-lane select (bit3 = bits 31:24), write data.
REQ-006 m0_ack  output  1  one-cycle completion pulse to CPU.
REQ-007 m0_rdata  output  32  registered read data, valid when m0_ack=1.
REQ-008 m1_req, m1_we, m1_addr, m1_sel, m1_wdata  input  1/1/32/4/32  debug/boot-loader requester, same rules as m0.
REQ-009 m1_ack, m1_rdata  output  1/32  same rules as m0.
REQ-010 stall_o  output  1  pipeline stall to CPU: m0_req=1 and m0_ack=0.
REQ-011 ram_ce, ram_we, ram_addr, ram_sel, ram_wdata  output  1/1/32/4/32  registered synchronous-RAM port.
REQ-012 ram_rdata  input  32  RAM read data, valid exactly RAM_LAT cycles after the cycle ram_ce=1 is driven.

Function
REQ-013 States IDLE, ACCESS, WAIT and RESP are implemented; exactly one requester is granted per transaction.
REQ-014 IDLE: if exactly one req is high, that requester is granted; if both are high, the requester not granted most recently (last_grant) wins.
REQ-015 On a grant, the granted requester's we/addr/sel/wdata are registered onto ram_*; ram_ce=1 is driven for exactly one cycle (ACCESS); last_grant is updated.
REQ-016 Write: ACCESS -> RESP; in RESP the granted ack=1 for one cycle, rdata is unchanged; RESP -> IDLE.
REQ-017 Read: ACCESS -> WAIT; WAIT counts RAM_LAT cycles; in the final WAIT cycle ram_rdata is captured into the granted rdata register; WAIT -> RESP -> IDLE.
REQ-018 Latency from req sampled in IDLE at cycle T: write ack at T+2; read ack at T+2+RAM_LAT.
REQ-019 Outside ACCESS, ram_ce=0 and ram_we=0; ram_addr/sel/wdata hold their last values.
REQ-020 The non-granted ack is 0 throughout a transaction; the non-granted rdata is unchanged.
REQ-021 The arbiter re-arbitrates only in IDLE; a req still high in the cycle after RESP is a new request; there are no back-to-back grants without an IDLE cycle.
REQ-022 Requests that change mid-transaction are ignored; only values registered at grant are used.
REQ-023 m_sel=4'b0000 is passed through unmodified as a normal transaction.
REQ-024 stall_o is combinational from m0_req and m0_ack; it is 0 in the m0 RESP cycle.
REQ-025 The WAIT counter width is sufficient for RAM_LAT=4; there is no wrap-around inside a transaction.

Reset
REQ-026 While rst=1 at a clock edge: state=IDLE, counter=0, last_grant=m1 (so m0 wins the first tie), ram_ce=0, ram_we=0, ram_addr=0, ram_sel=0, ram_wdata=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0.
REQ-027 Reset asserted mid-transaction aborts it: no ack is issued, ram_ce is 0 from the next cycle, and pending requests are re-arbitrated from IDLE after rst deasserts.

Verification
REQ-028 RAM_LAT=1: m0 read at addr 0x00000010 with RAM returning 0xDEADBEEF -> ram_ce=1 at T+1, m0_ack at T+3, m0_rdata=0xDEADBEEF, stall_o=1 during T..T+2.
REQ-029 m1 write addr 0x00000100, sel 4'b0011, wdata 0x1234ABCD -> ACCESS at T+1 with ram_we=1, ram_sel=4'b0011, ram_wdata=0x1234ABCD; m1_ack at T+2; m0_ack stays 0.
REQ-030 m0_req and m1_req both held high continuously after reset -> grants alternate m0, m1, m0, m1, with exactly one IDLE cycle between each RESP and the next ACCESS.
REQ-031 RAM_LAT=4: m0 read -> ack at T+6; m0_rdata equals the ram_rdata present in the 4th WAIT cycle; ram_ce is high for exactly one cycle.
REQ-032 rst pulsed for one cycle during WAIT of an m1 read -> m1_ack never asserted, all outputs at reset values; with m0_req and m1_req both high afterwards, m0 is granted first.
REQ-033 m0 changes m0_addr from 0x20 to 0x40 during WAIT -> ram_addr stays 0x20 and the data returned corresponds to 0x20.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of a single synchronous RAM port.
// One transaction at a time; ties go to the master not granted most recently.
module mem_bus_arbiter #(
    parameter int RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        stall_o,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(RAM_LAT - 1);

    state_t      state, state_nx;
    logic [2:0]  cnt;
    logic        grant, grant_nx;   // 0 = m0, 1 = m1
    logic        last_grant;
    logic        grant_en;
    logic        sel_we;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_sel;
    logic        wait_done;

    assign wait_done = (cnt == WAIT_LAST);

    always_comb begin
        state_nx = state;
        grant_en = 1'b0;
        grant_nx = grant;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_en = 1'b1;
                    grant_nx = (m0_req && m1_req) ? ~last_grant : m1_req;
                    state_nx = ACCESS;
                end
            end
            ACCESS:  state_nx = ram_we ? RESP : WAIT;
            WAIT:    if (wait_done) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sel_we    = grant_nx ? m1_we    : m0_we;
        sel_addr  = grant_nx ? m1_addr  : m0_addr;
        sel_sel   = grant_nx ? m1_sel   : m0_sel;
        sel_wdata = grant_nx ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Request fields are captured only at grant; later changes on m*_ are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_sel    <= '0;
            ram_wdata  <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            ram_ce <= 1'b0;
            ram_we <= 1'b0;
            if (grant_en) begin
                grant      <= grant_nx;
                last_grant <= grant_nx;
                ram_ce     <= 1'b1;
                ram_we     <= sel_we;
                ram_addr   <= sel_addr;
                ram_sel    <= sel_sel;
                ram_wdata  <= sel_wdata;
            end
            if (state == ACCESS)    cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 3'd1;
            if (state == WAIT && wait_done) begin
                if (grant) m1_rdata <= ram_rdata;
                else       m0_rdata <= ram_rdata;
            end
        end
    end

    assign m0_ack  = (state == RESP) && !grant;
    assign m1_ack  = (state == RESP) &&  grant;
    assign stall_o = m0_req && !m0_ack;

endmodule
